// File: rtl/clock_step_controller.sv
// Single-step / run / breakpoint clock-enable controller for a debug CPU.
// All asynchronous inputs are synchronized; the step button is debounced
// and edge-detected into a one-cycle step pulse that drives the mode FSM.
module clock_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic        i_oszClk,
  input  logic        i_reset,
  input  logic        i_btnStep,
  input  logic        i_swInstrNCycle,
  input  logic        i_swStepNRun,
  input  logic        i_swEnableBreakpoint,
  input  logic [15:0] i_breakpointAddress,
  input  logic [15:0] i_pc,
  input  logic        i_instrDone,
  output logic        o_cpuEnable,
  output logic        o_halted,
  output logic        o_stepPulse,
  output logic [15:0] o_cycleCount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CYCLE = 3'd1,
    INSTR = 3'd2,
    RUN   = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync_a;
  logic [3:0]    sync_b;
  logic          btn_s;
  logic          instr_s;
  logic          step_s;
  logic          bp_s;
  logic          db_level;
  logic          db_prev;
  logic [CW-1:0] db_count;
  logic [1:0]    warm;
  logic          ready;
  logic          mask;
  logic          mask_set;
  logic          bp_hit;
  state_t        state;
  state_t        next_state;

  assign btn_s   = sync_b[0];
  assign instr_s = sync_b[1];
  assign step_s  = sync_b[2];
  assign bp_s    = sync_b[3];

  // Two-flop synchronizers for button and switches
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle, i_btnStep};
      sync_b <= sync_a;
    end
  end

  // Debounce the step button and emit a pulse one cycle after the level rises
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      db_level    <= 1'b0;
      db_prev     <= 1'b0;
      db_count    <= '0;
      o_stepPulse <= 1'b0;
    end else begin
      db_prev     <= db_level;
      o_stepPulse <= db_level & ~db_prev;
      if (btn_s == db_level) begin
        db_count <= '0;
      end else if (db_count == DB_LAST) begin
        db_level <= btn_s;
        db_count <= '0;
      end else begin
        db_count <= db_count + 1'b1;
      end
    end
  end

  // Post-reset hold: the synchronizers reset to 0 (which reads as run mode),
  // so IDLE is not left until they carry real switch values
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      warm <= '0;
    end else if (warm != 2'd3) begin
      warm <= warm + 2'd1;
    end
  end

  assign ready  = (warm == 2'd3);
  assign bp_hit = bp_s & i_instrDone & (i_pc == i_breakpointAddress) & ~mask;

  // Next-state logic for the step/run/break FSM
  always_comb begin
    next_state = state;
    mask_set   = 1'b0;
    case (state)
      IDLE: begin
        if (ready) begin
          if (!step_s) begin
            next_state = RUN;
          end else if (o_stepPulse) begin
            next_state = instr_s ? INSTR : CYCLE;
          end
        end
      end
      CYCLE: next_state = IDLE;
      INSTR: begin
        if (i_instrDone) begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (step_s) begin
          next_state = IDLE;
        end else if (bp_hit) begin
          next_state = BREAK;
        end
      end
      BREAK: begin
        if (step_s) begin
          next_state = IDLE;
        end else if (o_stepPulse) begin
          next_state = RUN;
          mask_set   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with outputs registered from the next-state decode,
  // so enable/halted line up exactly with the state they describe
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      state       <= IDLE;
      o_cpuEnable <= 1'b0;
      o_halted    <= 1'b0;
    end else begin
      state       <= next_state;
      o_cpuEnable <= (next_state == CYCLE) || (next_state == INSTR) || (next_state == RUN);
      o_halted    <= (next_state == BREAK);
    end
  end

  // Breakpoint mask: set on resume from BREAK, cleared at the next instruction end
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      mask <= 1'b0;
    end else if (mask_set) begin
      mask <= 1'b1;
    end else if (o_cpuEnable && i_instrDone) begin
      mask <= 1'b0;
    end
  end

  // Count enabled CPU cycles, wrapping at 16 bits
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      o_cycleCount <= '0;
    end else if (o_cpuEnable) begin
      o_cycleCount <= o_cycleCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller with a small CPU model that
// finishes an instruction every 4th enabled cycle.
module tb_clock_step_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        sw_instr;
  logic        sw_step;
  logic        sw_bp;
  logic [15:0] bp_addr;
  logic [15:0] pc;
  logic        instr_done;
  logic        cpu_en;
  logic        halted;
  logic        pulse;
  logic [15:0] count;

  logic        model_clr;
  logic [1:0]  micro;
  logic [15:0] cur_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_step_controller #(.DEBOUNCE_CYCLES(8)) dut (
    .i_oszClk            (clk),
    .i_reset             (rst),
    .i_btnStep           (btn),
    .i_swInstrNCycle     (sw_instr),
    .i_swStepNRun        (sw_step),
    .i_swEnableBreakpoint(sw_bp),
    .i_breakpointAddress (bp_addr),
    .i_pc                (pc),
    .i_instrDone         (instr_done),
    .o_cpuEnable         (cpu_en),
    .o_halted            (halted),
    .o_stepPulse         (pulse),
    .o_cycleCount        (count)
  );

  // Program: 0x20 -> 0x24 -> 0x28, and 0x28 branches to itself
  function automatic logic [15:0] next_pc(input logic [15:0] p);
    if (p == 16'h0028) return 16'h0028;
    return p + 16'h0004;
  endfunction

  assign instr_done = (micro == 2'd3);
  assign pc         = next_pc(cur_pc);

  always @(posedge clk) begin
    if (model_clr) begin
      micro  <= 2'd0;
      cur_pc <= 16'h0020;
    end else if (cpu_en) begin
      micro <= micro + 2'd1;
      if (micro == 2'd3) cur_pc <= next_pc(cur_pc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic window(input int n, input int rel, output int en_n, output int pl_n);
    en_n = 0;
    pl_n = 0;
    for (int i = 1; i <= n; i++) begin
      if (i == rel) btn = 1'b0;
      tick();
      if (cpu_en) en_n++;
      if (pulse) pl_n++;
    end
  endtask

  initial begin
    int en;
    int pl;
    int acc;
    int first;
    logic prev_en;
    logic prev_halt;
    logic rise_prev_en;

    rst = 1'b1; btn = 1'b0; sw_instr = 1'b0; sw_step = 1'b1; sw_bp = 1'b0;
    bp_addr = 16'h0028; model_clr = 1'b1;
    repeat (3) tick();
    model_clr = 1'b0;
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pulse", {31'd0, pulse}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);

    // Idle in step mode after reset
    rst = 1'b0;
    window(10, 0, en, pl);
    chk("idle_en", en, 0);
    chk("idle_pulse", pl, 0);

    // Cycle step: button held 20 cycles
    btn = 1'b1;
    window(40, 21, en, pl);
    chk("cyc_pulses", pl, 1);
    chk("cyc_enables", en, 1);
    chk("cyc_count", {16'd0, count}, 32'd1);
    chk("cyc_idle", {31'd0, cpu_en}, 32'd0);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold
    acc = 0;
    for (int s = 0; s < 10; s++) begin
      btn = (s % 2 == 0);
      window(3, 0, en, pl);
      acc += pl;
    end
    chk("bounce_pulses", acc, 0);
    btn = 1'b1;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pulse && first == 0) first = i;
    end
    chk("bounce_latency", first, 11);
    window(15, 1, en, pl);
    chk("bounce_release_pulse", pl, 0);
    chk("bounce_count", {16'd0, count}, 32'd2);

    // Instruction step: 4 enabled cycles per instruction
    sw_instr = 1'b1;
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    btn = 1'b1;
    window(40, 21, en, pl);
    chk("instr_pulses", pl, 1);
    chk("instr_enables", en, 4);
    chk("instr_count", {16'd0, count}, 32'd6);
    chk("instr_idle", {31'd0, cpu_en}, 32'd0);

    // Run into breakpoint at 0x0028
    sw_instr = 1'b0;
    sw_bp = 1'b1;
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    sw_step = 1'b0;
    en = 0;
    prev_en = cpu_en;
    prev_halt = halted;
    rise_prev_en = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (cpu_en) en++;
      if (halted && !prev_halt) rise_prev_en = prev_en;
      prev_en = cpu_en;
      prev_halt = halted;
    end
    chk("bp1_enables", en, 8);
    chk("bp1_halted", {31'd0, halted}, 32'd1);
    chk("bp1_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("bp1_last_en_before_halt", {31'd0, rise_prev_en}, 32'd1);

    // Resume on a tight loop: masked once, halts on the next pass
    btn = 1'b1;
    window(60, 21, en, pl);
    chk("bp2_pulses", pl, 1);
    chk("bp2_enables", en, 8);
    chk("bp2_halted", {31'd0, halted}, 32'd1);

    // Step mode leaves BREAK
    sw_step = 1'b1;
    window(6, 0, en, pl);
    chk("brk_exit_halted", {31'd0, halted}, 32'd0);
    chk("brk_exit_en", {31'd0, cpu_en}, 32'd0);
    chk("brk_exit_count", {16'd0, count}, 32'd22);

    // Reset into run mode, then wrap the cycle counter
    sw_bp = 1'b0;
    sw_step = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst2_en", {31'd0, cpu_en}, 32'd0);
    chk("rst2_count", {16'd0, count}, 32'd0);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      tick();
      if (cpu_en) first = i;
    end
    chk("run_latency_ok", {31'd0, ((first >= 3) && (first <= 6))}, 32'd1);
    chk("run_first_count", {16'd0, count}, 32'd0);
    repeat (65534) tick();
    chk("wrap_fffe", {16'd0, count}, 32'h0000FFFE);
    chk("wrap_en", {31'd0, cpu_en}, 32'd1);
    tick();
    chk("wrap_ffff", {16'd0, count}, 32'h0000FFFF);
    tick();
    chk("wrap_0000", {16'd0, count}, 32'h00000000);
    tick();
    chk("wrap_0001", {16'd0, count}, 32'h00000001);

    // Reset pulse mid-run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_en", {31'd0, cpu_en}, 32'd0);
    chk("midrun_rst_count", {16'd0, count}, 32'd0);
    window(10, 0, en, pl);
    chk("midrun_resume_en", {31'd0, cpu_en}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
